alu_ctrl_pipe: RTL and testbench

- Registered ALU control stage at the ID/EX boundary of the pipelined MIPS datapath.
- Decodes ALUOp_i/funct_i into a 4-bit ALU operation and registers it alongside a valid bit, a jr flag and an illegal-op flag.
- Tracks multi-cycle mul/div for their parametrised latencies and back-pressures the ID stage while the ALU is occupied.
- Supports downstream stall and pipeline flush.

---
 rtl/alu_ctrl_pipe.sv | 150 +++++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_pipe.sv
`default_nettype none
// alu_ctrl_pipe: registered ALU-control stage at ID/EX with mul/div occupancy tracking.
// Revision 1.0
module alu_ctrl_pipe #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int DIV_EN  = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [2:0] ALUOp_i,
  input  logic [5:0] funct_i,
  input  logic       stall_i,
  input  logic       flush_i,
  output logic       ready_o,
  output logic [3:0] ALUCtrl_o,
  output logic       valid_o,
  output logic       jr_o,
  output logic       illegal_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [3:0] c_mul_lat = 4'(MUL_LAT);
  localparam logic [3:0] c_div_lat = 4'(DIV_LAT);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MULTI = 1'b1} state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_ctrl;
  logic       r_valid, r_jr, r_ill, r_busy, r_done;

  logic [3:0] w_ctrl;
  logic [3:0] w_lat;
  logic       w_jr, w_ill, w_accept;

  always_comb begin
    w_ctrl = 4'b1111;
    w_jr   = 1'b0;
    w_ill  = 1'b0;
    w_lat  = 4'd1;
    case (ALUOp_i)
      3'b100: begin
        case (funct_i)
          6'b100000: w_ctrl = 4'b0010;
          6'b100010: w_ctrl = 4'b0110;
          6'b100100: w_ctrl = 4'b0000;
          6'b100101: w_ctrl = 4'b0001;
          6'b101010: w_ctrl = 4'b0111;
          6'b000010: w_ctrl = 4'b0100;
          6'b000110: w_ctrl = 4'b0011;
          6'b000000: w_ctrl = 4'b1101;
          6'b011000: begin
            w_ctrl = 4'b1010;
            w_lat  = c_mul_lat;
          end
          6'b011010: begin
            if (DIV_EN != 0) begin
              w_ctrl = 4'b1100;
              w_lat  = c_div_lat;
            end else begin
              w_ill = 1'b1;
            end
          end
          6'b001000: begin
            w_ctrl = 4'b1011;
            w_jr   = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end
      3'b000:  w_ctrl = 4'b0010;
      3'b001:  w_ctrl = 4'b0110;
      3'b010:  w_ctrl = 4'b0101;
      3'b011:  w_ctrl = 4'b1000;
      3'b101:  w_ctrl = 4'b1001;
      3'b110:  w_ctrl = 4'b0110;
      default: w_ill  = 1'b1;
    endcase
  end

  // The final MULTI cycle (cnt==0) can already take the next op back-to-back.
  assign ready_o  = !stall_i && !flush_i &&
                    ((r_state == S_IDLE) || (r_cnt == 4'd0));
  assign w_accept = ready_o && valid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ctrl  <= 4'b0000;
      r_valid <= 1'b0;
      r_jr    <= 1'b0;
      r_ill   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_valid <= 1'b0;
      r_jr    <= 1'b0;
      r_ill   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!stall_i) begin
      if (w_accept) begin
        r_ctrl  <= w_ctrl;
        r_valid <= 1'b1;
        r_jr    <= w_jr;
        r_ill   <= w_ill;
        if (w_lat == 4'd1) begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_MULTI;
          r_cnt   <= w_lat - 4'd2;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
      end else if (r_state == S_MULTI) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else begin
        // Bubble: the control word is left as-is, only the qualifiers drop.
        r_valid <= 1'b0;
        r_jr    <= 1'b0;
        r_ill   <= 1'b0;
        r_done  <= 1'b0;
      end
    end
  end

  assign ALUCtrl_o = r_ctrl;
  assign valid_o   = r_valid;
  assign jr_o      = r_jr;
  assign illegal_o = r_ill;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_pipe.sv
`default_nettype none
// tb_alu_ctrl_pipe: scoreboard bench for alu_ctrl_pipe (default build and DIV_EN=0 build).
// Revision 1.0
module tb_alu_ctrl_pipe;

  logic       clk;
  logic       rst_n;
  logic       valid_i;
  logic [2:0] aluop;
  logic [5:0] funct;
  logic       stall;
  logic       flush;

  logic       ready, valid_o, jr_o, ill_o, busy_o, done_o;
  logic [3:0] ctrl_o;
  logic       nd_ready, nd_valid, nd_jr, nd_ill, nd_busy, nd_done;
  logic [3:0] nd_ctrl;

  wire [8:0] obs    = {valid_o, busy_o, done_o, jr_o, ill_o, ctrl_o};
  wire [8:0] nd_obs = {nd_valid, nd_busy, nd_done, nd_jr, nd_ill, nd_ctrl};

  typedef struct packed {
    logic [3:0] ctrl;
    logic       jr;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  alu_ctrl_pipe dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ALUOp_i(aluop), .funct_i(funct),
    .stall_i(stall), .flush_i(flush), .ready_o(ready), .ALUCtrl_o(ctrl_o),
    .valid_o(valid_o), .jr_o(jr_o), .illegal_o(ill_o), .busy_o(busy_o), .done_o(done_o)
  );

  alu_ctrl_pipe #(.MUL_LAT(4), .DIV_LAT(8), .DIV_EN(0)) dut_nd (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ALUOp_i(aluop), .funct_i(funct),
    .stall_i(stall), .flush_i(flush), .ready_o(nd_ready), .ALUCtrl_o(nd_ctrl),
    .valid_o(nd_valid), .jr_o(nd_jr), .illegal_o(nd_ill), .busy_o(nd_busy), .done_o(nd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [2:0] op, input logic [5:0] f);
    exp_t e;
    e = '{ctrl: 4'b1111, jr: 1'b0, ill: 1'b1};
    case (op)
      3'b100: case (f)
        6'b100000: e = '{4'b0010, 1'b0, 1'b0};
        6'b100010: e = '{4'b0110, 1'b0, 1'b0};
        6'b100100: e = '{4'b0000, 1'b0, 1'b0};
        6'b100101: e = '{4'b0001, 1'b0, 1'b0};
        6'b101010: e = '{4'b0111, 1'b0, 1'b0};
        6'b000010: e = '{4'b0100, 1'b0, 1'b0};
        6'b000110: e = '{4'b0011, 1'b0, 1'b0};
        6'b000000: e = '{4'b1101, 1'b0, 1'b0};
        6'b011000: e = '{4'b1010, 1'b0, 1'b0};
        6'b011010: e = '{4'b1100, 1'b0, 1'b0};
        6'b001000: e = '{4'b1011, 1'b1, 1'b0};
        default:   e = '{4'b1111, 1'b0, 1'b1};
      endcase
      3'b000: e = '{4'b0010, 1'b0, 1'b0};
      3'b001: e = '{4'b0110, 1'b0, 1'b0};
      3'b010: e = '{4'b0101, 1'b0, 1'b0};
      3'b011: e = '{4'b1000, 1'b0, 1'b0};
      3'b101: e = '{4'b1001, 1'b0, 1'b0};
      3'b110: e = '{4'b0110, 1'b0, 1'b0};
      default: e = '{4'b1111, 1'b0, 1'b1};
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f);
    valid_i = v;
    aluop   = op;
    funct   = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 3'b000, 6'b000000);
    step(); step();
    n_total++;
    if (obs !== 9'b0) $display("FAIL reset_outputs: got %b want %b", obs, 9'b0);
    else n_pass++;
    n_total++;
    if ({ready, nd_ready, nd_obs} !== {2'b11, 9'b0})
      $display("FAIL reset_ready: got %b want %b", {ready, nd_ready, nd_obs}, {2'b11, 9'b0});
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  // Single-cycle ops on consecutive cycles, then a bubble.
  task automatic test_stream(input int n, input logic [2:0] ops [16], input logic [5:0] fs [16]);
    exp_t e;
    logic [8:0] want;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, ops[i], fs[i]);
      #1;
      n_total++;
      if (ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", i, ready);
      else n_pass++;
      sb.push_back(model(ops[i], fs[i]));
      step();
      e = sb.pop_front();
      want = {3'b101, e.jr, e.ill, e.ctrl};
      n_total++;
      if (obs !== want) $display("FAIL stream_out[%0d]: got %b want %b", i, obs, want);
      else n_pass++;
    end
    drive(1'b0, 3'b000, 6'b000000);
    step();
    want = {5'b00000, e.ctrl};
    n_total++;
    if (obs !== want) $display("FAIL bubble: got %b want %b", obs, want);
    else n_pass++;
  endtask

  task automatic test_mul();
    exp_t e;
    logic [8:0] want;
    drive(1'b1, 3'b100, 6'b011000);
    sb.push_back(model(3'b100, 6'b011000));
    step();
    drive(1'b0, 3'b000, 6'b000000);
    e = sb.pop_front();
    for (int k = 1; k <= 4; k++) begin
      want = {1'b1, (k < 4), (k == 4), e.jr, e.ill, e.ctrl};
      n_total++;
      if (obs !== want) $display("FAIL mul_cycle[%0d]: got %b want %b", k, obs, want);
      else n_pass++;
      n_total++;
      if (ready !== (k >= 3)) $display("FAIL mul_ready[%0d]: got %b want %b", k, ready, (k >= 3));
      else n_pass++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [8:0] want;
    int guard;
    drive(1'b1, 3'b100, 6'b011000);
    sb.push_back(model(3'b100, 6'b011000));
    step();
    e = sb.pop_front();
    drive(1'b1, 3'b100, 6'b100010);
    guard = 0;
    #1;
    while (!ready && guard < 20) begin
      want = {3'b110, e.jr, e.ill, e.ctrl};
      n_total++;
      if (obs !== want) $display("FAIL b2b_busy[%0d]: got %b want %b", guard, obs, want);
      else n_pass++;
      step();
      guard++;
    end
    n_total++;
    if (guard != 2) $display("FAIL b2b_stall_cycles: got %0d want 2", guard);
    else n_pass++;
    sb.push_back(model(3'b100, 6'b100010));
    step();
    drive(1'b0, 3'b000, 6'b000000);
    e = sb.pop_front();
    want = {3'b101, e.jr, e.ill, e.ctrl};
    n_total++;
    if (obs !== want) $display("FAIL b2b_sub: got %b want %b", obs, want);
    else n_pass++;
    step();
  endtask

  task automatic test_div_stall();
    exp_t e;
    logic [8:0] want;
    logic r_exp;
    drive(1'b1, 3'b100, 6'b011010);
    sb.push_back(model(3'b100, 6'b011010));
    step();
    drive(1'b0, 3'b000, 6'b000000);
    e = sb.pop_front();
    n_total++;
    if (nd_obs !== {3'b101, 1'b0, 1'b1, 4'b1111})
      $display("FAIL div_disabled: got %b want %b", nd_obs, {5'b10101, 4'b1111});
    else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      stall = (k == 3 || k == 4);
      #1;
      want  = {1'b1, (k <= 9), (k == 10), e.jr, e.ill, e.ctrl};
      r_exp = !stall && (k >= 9);
      n_total++;
      if (obs !== want) $display("FAIL div_cycle[%0d]: got %b want %b", k, obs, want);
      else n_pass++;
      n_total++;
      if (ready !== r_exp) $display("FAIL div_ready[%0d]: got %b want %b", k, ready, r_exp);
      else n_pass++;
      step();
    end
    stall = 1'b0;
    step();
  endtask

  task automatic test_flush();
    logic [8:0] want;
    drive(1'b1, 3'b100, 6'b011000);
    step();
    drive(1'b0, 3'b000, 6'b000000);
    step();
    flush = 1'b1;
    #1;
    n_total++;
    if (ready !== 1'b0) $display("FAIL flush_ready_low: got %b want 0", ready);
    else n_pass++;
    step();
    flush = 1'b0;
    #1;
    want = {5'b00000, 4'b1010};
    n_total++;
    if ({ready, obs} !== {1'b1, want}) $display("FAIL flush_kill: got %b want %b", {ready, obs}, {1'b1, want});
    else n_pass++;
    step(); step();
    n_total++;
    if (obs !== want) $display("FAIL flush_no_done: got %b want %b", obs, want);
    else n_pass++;
    drive(1'b1, 3'b000, 6'b000000);
    step();
    drive(1'b0, 3'b000, 6'b000000);
    flush = 1'b1;
    stall = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    want = {5'b00000, 4'b0010};
    n_total++;
    if (obs !== want) $display("FAIL flush_over_stall: got %b want %b", obs, want);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [8:0] want;
    drive(1'b1, 3'b100, 6'b011010);
    step();
    drive(1'b0, 3'b000, 6'b000000);
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (obs !== 9'b0) $display("FAIL async_reset: got %b want %b", obs, 9'b0);
    else n_pass++;
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    n_total++;
    if (obs !== 9'b0) $display("FAIL reset_no_done: got %b want %b", obs, 9'b0);
    else n_pass++;
    drive(1'b1, 3'b000, 6'b101010);
    sb.push_back(model(3'b000, 6'b101010));
    step();
    drive(1'b0, 3'b000, 6'b000000);
    e = sb.pop_front();
    want = {3'b101, e.jr, e.ill, e.ctrl};
    n_total++;
    if (obs !== want) $display("FAIL post_reset_addi: got %b want %b", obs, want);
    else n_pass++;
  endtask

  initial begin
    logic [2:0] ops [16];
    logic [5:0] fs  [16];
    test_reset();

    ops[0] = 3'b100; fs[0] = 6'b100000;
    ops[1] = 3'b100; fs[1] = 6'b100101;
    ops[2] = 3'b000; fs[2] = 6'b111111;
    test_stream(3, ops, fs);

    ops[0]  = 3'b100; fs[0]  = 6'b001000;
    ops[1]  = 3'b100; fs[1]  = 6'b111111;
    ops[2]  = 3'b111; fs[2]  = 6'b100000;
    ops[3]  = 3'b100; fs[3]  = 6'b100010;
    ops[4]  = 3'b100; fs[4]  = 6'b100100;
    ops[5]  = 3'b100; fs[5]  = 6'b101010;
    ops[6]  = 3'b100; fs[6]  = 6'b000010;
    ops[7]  = 3'b100; fs[7]  = 6'b000110;
    ops[8]  = 3'b100; fs[8]  = 6'b000000;
    ops[9]  = 3'b001; fs[9]  = 6'b000000;
    ops[10] = 3'b010; fs[10] = 6'b000000;
    ops[11] = 3'b011; fs[11] = 6'b000000;
    ops[12] = 3'b101; fs[12] = 6'b000000;
    ops[13] = 3'b110; fs[13] = 6'b000000;
    test_stream(14, ops, fs);

    test_mul();
    test_back_to_back();
    test_div_stall();
    test_flush();
    test_async_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
